// File: rtl/fir_seq_ctrl.sv
// Sequencer for a single-MAC FIR: accepts one sample, steps the shared MAC over
// all taps, loads the output register and holds the result until consumed.
// Optional handshake counter enabled by defining FIR_CTRL_STATS_EN.
module fir_seq_ctrl #(
  parameter int unsigned TAPS   = 3,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ld_reg,
  output logic [ADDR_W-1:0] tap_idx,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              ld_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef FIR_CTRL_STATS_EN
  ,
  output logic [15:0]       out_count
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitIn,
    StMac,
    StLoad,
    StOut,
    StFinish
  } state_e;

  localparam logic [ADDR_W-1:0] LastTap = ADDR_W'(TAPS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tap_q, tap_d;
  logic              stop_pend_q, stop_pend_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tap_q       <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tap_d       = '0;
    stop_pend_d = stop_pend_q | (stop & (state_q != StIdle));
    in_ready    = 1'b0;
    ld_reg      = 1'b0;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    ld_out      = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    busy        = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StWaitIn;
      end
      StWaitIn: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // A sample arriving with stop is still processed; stop stays pending.
          ld_reg  = 1'b1;
          state_d = StMac;
        end else if (stop || stop_pend_q) begin
          state_d = StFinish;
        end
      end
      StMac: begin
        mac_en  = 1'b1;
        mac_clr = (tap_q == '0);
        if (tap_q == LastTap) begin
          state_d = StLoad;
        end else begin
          tap_d = tap_q + ADDR_W'(1);
        end
      end
      StLoad: begin
        ld_out  = 1'b1;
        state_d = StOut;
      end
      StOut: begin
        out_valid = 1'b1;
        if (out_ready) state_d = (stop || stop_pend_q) ? StFinish : StWaitIn;
      end
      StFinish: begin
        done        = 1'b1;
        stop_pend_d = 1'b0;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign tap_idx = tap_q;

`ifdef FIR_CTRL_STATS_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (state_q == StIdle && start) begin
      count_d = '0;
    end else if (state_q == StOut && out_ready && count_q != 16'hFFFF) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: a TAPS=3 instance for timing, backpressure,
// stop and reset cases, and a TAPS=5 instance for the wider tap sequence.
module tb_fir_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // TAPS=3 instance
  logic       start, stop, in_valid, out_ready;
  logic       in_ready, ld_reg, mac_clr, mac_en, ld_out, out_valid, busy, done;
  logic [1:0] tap_idx;
  // TAPS=5 instance
  logic       start5, stop5, in_valid5, out_ready5;
  logic       in_ready5, ld_reg5, mac_clr5, mac_en5, ld_out5, out_valid5, busy5, done5;
  logic [2:0] tap_idx5;
`ifdef FIR_CTRL_STATS_EN
  logic [15:0] out_count, out_count5;
`endif

  fir_seq_ctrl #(.TAPS(3), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .in_ready(in_ready), .ld_reg(ld_reg), .tap_idx(tap_idx), .mac_clr(mac_clr),
    .mac_en(mac_en), .ld_out(ld_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
`ifdef FIR_CTRL_STATS_EN
    , .out_count(out_count)
`endif
  );

  fir_seq_ctrl #(.TAPS(5), .ADDR_W(3)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .stop(stop5), .in_valid(in_valid5),
    .in_ready(in_ready5), .ld_reg(ld_reg5), .tap_idx(tap_idx5), .mac_clr(mac_clr5),
    .mac_en(mac_en5), .ld_out(ld_out5), .out_valid(out_valid5), .out_ready(out_ready5),
    .busy(busy5), .done(done5)
`ifdef FIR_CTRL_STATS_EN
    , .out_count(out_count5)
`endif
  );

  // Output vector: {in_ready, ld_reg, mac_clr, mac_en, ld_out, out_valid, busy, done}
  localparam logic [7:0] OIdle  = 8'b0000_0000;
  localparam logic [7:0] OWait  = 8'b1000_0010;
  localparam logic [7:0] OAcc   = 8'b1100_0010;
  localparam logic [7:0] OMac0  = 8'b0011_0010;
  localparam logic [7:0] OMacN  = 8'b0001_0010;
  localparam logic [7:0] OLoad  = 8'b0000_1010;
  localparam logic [7:0] OOut   = 8'b0000_0110;
  localparam logic [7:0] OFin   = 8'b0000_0011;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Settle combinational outputs after inputs change, then compare.
  task automatic chk3(input string tag, input logic [7:0] o, input logic [1:0] t);
    #2;
    chk(tag, {22'd0, in_ready, ld_reg, mac_clr, mac_en, ld_out, out_valid, busy, done, tap_idx},
        {22'd0, o, t});
  endtask

  task automatic chk5(input string tag, input logic [7:0] o, input logic [2:0] t);
    #2;
    chk(tag, {21'd0, in_ready5, ld_reg5, mac_clr5, mac_en5, ld_out5, out_valid5, busy5, done5,
              tap_idx5}, {21'd0, o, t});
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; in_valid = 0; out_ready = 0;
    start5 = 0; stop5 = 0; in_valid5 = 0; out_ready5 = 0;
    tick(); tick();
    chk3("reset_idle", OIdle, 2'd0);
    start = 1; stop = 1; chk3("reset_prio", OIdle, 2'd0);
    tick(); stop = 0;
    chk3("reset_held", OIdle, 2'd0);

    // Basic latency: start at cycle 0, sample at cycle 2
    tick(); rst = 0; start = 1;     chk3("c0_idle", OIdle, 2'd0);
    tick(); start = 0;              chk3("c1_wait", OWait, 2'd0);
    tick(); in_valid = 1;           chk3("c2_ldreg", OAcc, 2'd0);
    tick(); in_valid = 0; start = 1; chk3("c3_mac0", OMac0, 2'd0);
    tick(); start = 0;              chk3("c4_mac1", OMacN, 2'd1);
    tick();                         chk3("c5_mac2", OMacN, 2'd2);
    tick();                         chk3("c6_ldout", OLoad, 2'd0);
    // Backpressure for four cycles
    for (int i = 0; i < 4; i++) begin
      tick();                       chk3("out_hold", OOut, 2'd0);
    end
    tick(); out_ready = 1;          chk3("out_hs", OOut, 2'd0);
    tick(); out_ready = 0;          chk3("after_hs_wait", OWait, 2'd0);

    // Stop pulsed during MAC
    tick(); in_valid = 1;           chk3("s1_accept", OAcc, 2'd0);
    tick(); in_valid = 0; stop = 1; chk3("s1_mac0", OMac0, 2'd0);
    tick(); stop = 0;               chk3("s1_mac1", OMacN, 2'd1);
    tick();                         chk3("s1_mac2", OMacN, 2'd2);
    tick();                         chk3("s1_load", OLoad, 2'd0);
    tick(); out_ready = 1;          chk3("s1_out", OOut, 2'd0);
    tick(); out_ready = 0;          chk3("s1_done", OFin, 2'd0);
    tick();                         chk3("s1_idle", OIdle, 2'd0);

    // stop together with in_valid in WAIT_IN
    start = 1;
    tick(); start = 0; in_valid = 1; stop = 1; chk3("s2_accept", OAcc, 2'd0);
    tick(); in_valid = 0; stop = 0; chk3("s2_mac0", OMac0, 2'd0);
    tick();                         chk3("s2_mac1", OMacN, 2'd1);
    tick();                         chk3("s2_mac2", OMacN, 2'd2);
    tick();                         chk3("s2_load", OLoad, 2'd0);
    tick(); out_ready = 1;          chk3("s2_out", OOut, 2'd0);
    tick(); out_ready = 0;          chk3("s2_done", OFin, 2'd0);
    tick();                         chk3("s2_idle", OIdle, 2'd0);

    // stop alone in WAIT_IN
    start = 1;
    tick(); start = 0; stop = 1;    chk3("s3_wait", OWait, 2'd0);
    tick(); stop = 0;               chk3("s3_done", OFin, 2'd0);
    tick();                         chk3("s3_idle", OIdle, 2'd0);

    // Reset mid-MAC
    start = 1;
    tick(); start = 0; in_valid = 1; chk3("r_accept", OAcc, 2'd0);
    tick(); in_valid = 0;           chk3("r_mac0", OMac0, 2'd0);
    tick(); rst = 1;                chk3("r_mac1", OMacN, 2'd1);
    tick(); rst = 0;                chk3("r_idle", OIdle, 2'd0);
    tick();                         chk3("r_no_done", OIdle, 2'd0);
    start = 1;
    tick(); start = 0; in_valid = 1; chk3("r2_accept", OAcc, 2'd0);
    tick(); in_valid = 0;           chk3("r2_mac0", OMac0, 2'd0);
    tick();                         chk3("r2_mac1", OMacN, 2'd1);
    tick();                         chk3("r2_mac2", OMacN, 2'd2);
    tick();                         chk3("r2_load", OLoad, 2'd0);
    tick(); out_ready = 1;          chk3("r2_out", OOut, 2'd0);
    tick(); out_ready = 0;          chk3("r2_wait", OWait, 2'd0);

    // TAPS=5 instance: three samples, then stop
    start5 = 1;                     chk5("t5_idle", OIdle, 3'd0);
    tick(); start5 = 0;             chk5("t5_wait", OWait, 3'd0);
    for (int s = 0; s < 3; s++) begin
      in_valid5 = 1;                chk5("t5_accept", OAcc, 3'd0);
      tick(); in_valid5 = 0;        chk5("t5_mac0", OMac0, 3'd0);
      for (int t = 1; t < 5; t++) begin
        tick();                     chk5("t5_macn", OMacN, 3'(t));
      end
      tick();                       chk5("t5_load", OLoad, 3'd0);
      tick(); out_ready5 = 1;       chk5("t5_out", OOut, 3'd0);
      tick(); out_ready5 = 0;
    end
    stop5 = 1;                      chk5("t5_stop_wait", OWait, 3'd0);
    tick(); stop5 = 0;              chk5("t5_done", OFin, 3'd0);
    tick();                         chk5("t5_idle", OIdle, 3'd0);
`ifdef FIR_CTRL_STATS_EN
    chk("t5_count", {16'd0, out_count5}, 32'd3);
    start5 = 1;
    tick(); start5 = 0;
    chk("t5_count_clr", {16'd0, out_count5}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
